// File: rtl/alu_4bit.sv
// Registered 4-bit ALU: eight opcodes, Zero/Carry/Overflow flags, one-cycle latency.
// Define ALU_4BIT_SHIFT_CARRY_EN to report the shifted-out bit in Carry for SHL/SHR.
module alu_4bit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALU_Sel,
  output logic [WIDTH-1:0] ALU_Result,
  output logic             Zero,
  output logic             Carry,
  output logic             Overflow
);

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpNot = 3'b101,
    OpShl = 3'b110,
    OpShr = 3'b111
  } op_e;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] result_d;
  logic             carry_d;
  logic             overflow_d;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  // Subtraction as a + ~b + 1 so the carry-out means "no borrow".
  assign diff_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    result_d   = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    unique case (op_e'(ALU_Sel))
      OpAdd: begin
        result_d   = sum_ext[WIDTH-1:0];
        carry_d    = sum_ext[WIDTH];
        overflow_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        result_d   = diff_ext[WIDTH-1:0];
        carry_d    = diff_ext[WIDTH];
        overflow_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OpAnd: result_d = a & b;
      OpOr:  result_d = a | b;
      OpXor: result_d = a ^ b;
      OpNot: result_d = ~a;
      OpShl: begin
        result_d = {a[WIDTH-2:0], 1'b0};
`ifdef ALU_4BIT_SHIFT_CARRY_EN
        carry_d  = a[WIDTH-1];
`else
        carry_d  = 1'b0;
`endif
      end
      OpShr: begin
        result_d = {1'b0, a[WIDTH-1:1]};
`ifdef ALU_4BIT_SHIFT_CARRY_EN
        carry_d  = a[0];
`else
        carry_d  = 1'b0;
`endif
      end
      default: begin
        result_d   = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALU_Result <= '0;
      Zero       <= 1'b1;
      Carry      <= 1'b0;
      Overflow   <= 1'b0;
    end else begin
      ALU_Result <= result_d;
      Zero       <= (result_d == '0);
      Carry      <= carry_d;
      Overflow   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_alu_4bit.sv
// Self-checking bench for alu_4bit: directed vector table, reset sequences and a
// back-to-back random stream checked against an integer reference model.
module tb_alu_4bit;

  logic       clk;
  logic       reset;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] ALU_Sel;
  logic [3:0] ALU_Result;
  logic       Zero;
  logic       Carry;
  logic       Overflow;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef ALU_4BIT_SHIFT_CARRY_EN
  localparam logic SC = 1'b1;
`else
  localparam logic SC = 1'b0;
`endif

  alu_4bit dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .ALU_Sel    (ALU_Sel),
    .ALU_Result (ALU_Result),
    .Zero       (Zero),
    .Carry      (Carry),
    .Overflow   (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [3:0] va;
    logic [3:0] vb;
    logic [3:0] r;
    logic       z;
    logic       c;
    logic       v;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [3:0] r, input logic z,
                           input logic c, input logic v);
    check({name, ".result"}, ALU_Result, r);
    check({name, ".zero"}, {3'b0, Zero}, {3'b0, z});
    check({name, ".carry"}, {3'b0, Carry}, {3'b0, c});
    check({name, ".ovf"}, {3'b0, Overflow}, {3'b0, v});
  endtask

  // Reference model in integer arithmetic; returns {r, z, c, v}.
  function automatic logic [6:0] model(input logic [2:0] sel, input logic [3:0] x,
                                       input logic [3:0] y);
    int ux, uy, sx, sy, t;
    logic [3:0] r;
    logic c, v;
    ux = int'(x);
    uy = int'(y);
    sx = (ux > 7) ? ux - 16 : ux;
    sy = (uy > 7) ? uy - 16 : uy;
    c = 1'b0;
    v = 1'b0;
    r = 4'd0;
    case (sel)
      3'd0: begin t = ux + uy; r = 4'(t % 16); c = (t > 15);
                  v = (sx + sy > 7) || (sx + sy < -8); end
      3'd1: begin t = ux - uy + 16; r = 4'(t % 16); c = (ux >= uy);
                  v = (sx - sy > 7) || (sx - sy < -8); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = 4'(15 - ux);
      3'd6: begin r = 4'((ux * 2) % 16); c = SC & (ux >= 8); end
      default: begin r = 4'(ux / 2); c = SC & (ux % 2 == 1); end
    endcase
    model = {r, (r == 4'd0), c, v};
  endfunction

  task automatic apply(input logic [2:0] sel, input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    ALU_Sel = sel;
    a       = x;
    b       = y;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] exp_m;
    logic [2:0] s;
    logic [3:0] x, y;

    vecs[0]  = '{3'b000, 4'd7,    4'd1,    4'd8,    1'b0, 1'b0, 1'b1};
    vecs[1]  = '{3'b000, 4'd15,   4'd1,    4'd0,    1'b1, 1'b1, 1'b0};
    vecs[2]  = '{3'b001, 4'd8,    4'd1,    4'd7,    1'b0, 1'b1, 1'b1};
    vecs[3]  = '{3'b001, 4'd2,    4'd5,    4'd13,   1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'b001, 4'd5,    4'd5,    4'd0,    1'b1, 1'b1, 1'b0};
    vecs[5]  = '{3'b010, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'b011, 4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b100, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b101, 4'b1100, 4'b1010, 4'b0011, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'b010, 4'b0101, 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'b110, 4'b1001, 4'b0110, 4'b0010, 1'b0, SC,   1'b0};
    vecs[11] = '{3'b111, 4'b1001, 4'b1111, 4'b0100, 1'b0, SC,   1'b0};
    vecs[12] = '{3'b000, 4'd9,    4'd9,    4'd2,    1'b0, 1'b1, 1'b1};
    vecs[13] = '{3'b101, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};

    reset   = 1'b1;
    a       = 4'd0;
    b       = 4'd0;
    ALU_Sel = 3'd0;
    #12;
    check_all("reset_init", 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    apply(3'b000, 4'd3, 4'd4);
    check_all("add_3_4", 4'd7, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].sel, vecs[i].va, vecs[i].vb);
      check_all($sformatf("vec%0d", i), vecs[i].r, vecs[i].z, vecs[i].c, vecs[i].v);
    end

    // Async reset mid-cycle, held across an edge to discard the pending op.
    apply(3'b000, 4'd15, 4'd1);
    check_all("pre_reset", 4'd0, 1'b1, 1'b1, 1'b0);
    apply(3'b000, 4'd7, 4'd1);
    #2;
    reset = 1'b1;
    #1;
    check_all("async_reset", 4'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("reset_hold", 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset   = 1'b0;
    ALU_Sel = 3'b001;
    a       = 4'd8;
    b       = 4'd1;
    #1;
    check_all("reset_release", 4'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("first_after_reset", 4'd7, 1'b0, 1'b1, 1'b1);

    // Back-to-back stream: each negedge checks the capture of the previous inputs.
    @(negedge clk);
    ALU_Sel = 3'd0;
    a       = 4'd1;
    b       = 4'd2;
    exp_m   = model(ALU_Sel, a, b);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      check_all($sformatf("stream%0d", i), exp_m[6:3], exp_m[2], exp_m[1], exp_m[0]);
      s       = 3'(i % 8);
      x       = 4'($urandom_range(0, 15));
      y       = 4'($urandom_range(0, 15));
      ALU_Sel = s;
      a       = x;
      b       = y;
      exp_m   = model(s, x, y);
    end
    @(negedge clk);
    check_all("stream_last", exp_m[6:3], exp_m[2], exp_m[1], exp_m[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_4bit.md
# alu_4bit

Registered 4-bit arithmetic/logic unit with eight operations selected by a 3-bit opcode. It produces a 4-bit result plus Zero, Carry and signed Overflow flags. It serves as the datapath ALU of small control-oriented cores and as a standalone arithmetic block. All outputs are registered on one clock with an asynchronous active-high reset.

## Interface
- WIDTH, 4, operand/result width; only 4 is supported, and the port widths below are fixed at 4.
- clk  input  1  clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset; clears all output registers.
- a  input  4  operand A; signed two's complement for Overflow, unsigned for Carry.
- b  input  4  operand B.
- ALU_Sel  input  3  operation select.
- ALU_Result  output  4  registered result.
- Zero  output  1  registered; 1 when the registered result is 4'b0000.
- Carry  output  1  registered carry/shift-out flag.
- Overflow  output  1  registered signed-overflow flag.

## Operation
Opcode mapping (R = result before registering):
- 000 ADD: R = a + b (mod 16); Carry = bit 4 of the 5-bit unsigned sum; Overflow = (a[3] == b[3]) && (R[3] != a[3]).
- 001 SUB: R = a - b, computed as a + ~b + 1; Carry = carry out of that sum, so Carry = 1 when a >= b unsigned; Overflow = (a[3] != b[3]) && (R[3] != a[3]).
- 010 AND: R = a & b.
- 011 OR: R = a | b.
- 100 XOR: R = a ^ b.
- 101 NOT: R = ~a; b is ignored.
- 110 SHL: R = {a[2:0], 1'b0}; b is ignored.
- 111 SHR: R = {1'b0, a[3:1]} (logical shift); b is ignored.

Flag rules:
- Zero = (R == 0) for every opcode.
- Overflow = 0 for all opcodes except ADD and SUB.
- Carry = 0 for the logic opcodes 010–101; shift behaviour is set in Configuration.
- Opcode decoding is full. No opcode value is illegal, and no X is produced for known inputs.

## Timing
- Result and flags are computed combinationally from a, b and ALU_Sel.
- They are captured on every rising clk edge. Latency is 1 cycle: inputs present before edge N appear on the outputs after edge N.
- There is no enable and no handshake; the unit issues a new operation every cycle (throughput 1/cycle).
- When reset is asserted, at any time and independent of clk: ALU_Result = 0, Zero = 1, Carry = 0, Overflow = 0.
- Zero reads 1 during reset because the reset result is 0.
- Reset asserted mid-stream discards the pending operation. The first capture after reset deasserts uses the inputs present at that edge.
- Outputs change only on a clk edge or on reset assertion.

## Configuration
- ALU_4BIT_SHIFT_CARRY_EN defined: shifts report the bit shifted out in Carry. SHL gives Carry = a[3]; SHR gives Carry = a[0].
- ALU_4BIT_SHIFT_CARRY_EN undefined: Carry = 0 for SHL and SHR.
- All other behaviour is identical in both builds.

## Test plan
- Reset asserted asynchronously mid-cycle -> outputs go immediately to ALU_Result=0, Zero=1, Carry=0, Overflow=0. After release, ADD a=3,b=4 -> next edge gives Result=7, flags 0.
- ADD a=7,b=1 -> Result=8, Overflow=1, Carry=0, Zero=0. ADD a=15,b=1 -> Result=0, Carry=1, Zero=1, Overflow=0.
- SUB a=8,b=1 -> Result=7, Overflow=1, Carry=1. SUB a=2,b=5 -> Result=13, Carry=0, Overflow=0. SUB a=5,b=5 -> Result=0, Zero=1, Carry=1.
- Logic ops with a=4'b1100, b=4'b1010: AND -> 1000, OR -> 1110, XOR -> 0110, NOT -> 0011. Carry and Overflow stay 0 for all four; AND with a=4'b0101, b=4'b1010 -> Zero=1.
- SHL a=4'b1001 -> 0010; SHR a=4'b1001 -> 0100. Carry = 1 for both with ALU_4BIT_SHIFT_CARRY_EN defined, and 0 for both without it.
- Back-to-back opcode changes on every edge (all 8 opcodes, random operands) -> each output equals the reference model of the previous cycle's inputs, with no bubbles.
